// File: rtl/calc_stream.sv
// rtl/calc_stream.sv - streaming calculator: collect framed operands, execute, emit status and result
//
// Purpose: pops a header word and two OP_W-bit operands (NW words each, LS word first)
// from a show-ahead input FIFO, runs one of eight operations (MUL is a one-bit-per-cycle
// shift-add), then pushes a status word and NR result words into an output FIFO.
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset
//   datain   in   input FIFO head word (valid while empty=0)
//   empty    in   input FIFO empty
//   rden     out  input pop (combinational)
//   full     in   output FIFO full
//   dataout  out  output word (registered)
//   wren     out  output push (registered, one cycle per word)
//   busy     out  high whenever a frame is in progress

module calc_stream #(
    parameter int WORD_W = 48,
    parameter int OP_W   = 80
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] datain,
    input  logic              empty,
    output logic              rden,
    input  logic              full,
    output logic [WORD_W-1:0] dataout,
    output logic              wren,
    output logic              busy
);

    localparam int NW      = (OP_W + WORD_W - 1) / WORD_W;
    localparam int NR      = (2 * OP_W + WORD_W - 1) / WORD_W;
    localparam int CNT_MAX = (OP_W > NR) ? OP_W : NR;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_OR  = 3'd4;
    localparam logic [2:0] OP_XOR = 3'd5;
    localparam logic [2:0] OP_CMP = 3'd6;
    localparam logic [2:0] OP_RSV = 3'd7;

    typedef enum logic [2:0] {
        S_HDR,
        S_COL_A,
        S_COL_B,
        S_EXEC,
        S_EMIT_HDR,
        S_EMIT
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [2:0]          r_op;
    logic [OP_W-1:0]     r_a;
    logic [OP_W-1:0]     r_b;
    logic [2*OP_W-1:0]   r_res;
    logic [CNT_W-1:0]    r_cnt;
    logic [WORD_W-1:0]   r_dataout;
    logic                r_wren;

    logic                w_rden;
    logic                w_busy;
    logic                w_last_nw;
    logic                w_last_nr;
    logic                w_last_mul;
    logic [2*OP_W-1:0]   w_alu;
    logic [OP_W:0]       w_mul_sum;
    logic [WORD_W-1:0]   w_status;
    logic [WORD_W-1:0]   w_res_word;

    assign w_last_nw  = (r_cnt == CNT_W'(NW - 1));
    assign w_last_nr  = (r_cnt == CNT_W'(NR - 1));
    assign w_last_mul = (r_cnt == CNT_W'(OP_W - 1));

    assign rden    = w_rden;
    assign busy    = w_busy;
    assign dataout = r_dataout;
    assign wren    = r_wren;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_HDR;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_rden = 1'b0;
        w_busy = (r_state != S_HDR);
        case (r_state)
            S_HDR: begin
                if (!empty) begin
                    w_rden = 1'b1;
                    w_next = S_COL_A;
                end
            end
            S_COL_A: begin
                if (!empty) begin
                    w_rden = 1'b1;
                    if (w_last_nw) w_next = S_COL_B;
                end
            end
            S_COL_B: begin
                if (!empty) begin
                    w_rden = 1'b1;
                    if (w_last_nw) w_next = S_EXEC;
                end
            end
            S_EXEC: begin
                if (r_op != OP_MUL || w_last_mul) w_next = S_EMIT_HDR;
            end
            S_EMIT_HDR: begin
                if (!full) w_next = S_EMIT;
            end
            S_EMIT: begin
                if (!full && w_last_nr) w_next = S_HDR;
            end
            default: w_next = S_HDR;
        endcase
    end

    // Single-cycle operations; MUL and the reserved opcode leave this at zero.
    always_comb begin
        w_alu = '0;
        case (r_op)
            OP_ADD: w_alu[OP_W:0] = {1'b0, r_a} + {1'b0, r_b};
            OP_SUB: begin
                w_alu[OP_W-1:0] = r_a - r_b;
                w_alu[OP_W]     = (r_a < r_b);
            end
            OP_AND: w_alu[OP_W-1:0] = r_a & r_b;
            OP_OR:  w_alu[OP_W-1:0] = r_a | r_b;
            OP_XOR: w_alu[OP_W-1:0] = r_a ^ r_b;
            OP_CMP: w_alu[2:0] = {r_a > r_b, r_a == r_b, r_a < r_b};
            default: w_alu = '0;
        endcase
    end

    // Right-shifting product register: the upper half accumulates A whenever the
    // current multiplier LSB is set, and settled low bits shift down into the lower
    // half. After OP_W steps r_res holds the full product.
    assign w_mul_sum = {1'b0, r_res[2*OP_W-1:OP_W]} + {1'b0, (r_b[0] ? r_a : {OP_W{1'b0}})};

    always_comb begin
        w_status      = '0;
        w_status[2:0] = r_op;
        w_status[3]   = (r_op == OP_RSV);
        w_status[4]   = (r_res == '0);
        w_status[5]   = (r_op == OP_ADD || r_op == OP_SUB) && r_res[OP_W];
    end

    // Result word r_cnt; bits past 2*OP_W in the final word stay zero.
    always_comb begin
        w_res_word = '0;
        for (int j = 0; j < 2 * OP_W; j++) begin
            if (r_cnt == CNT_W'(j / WORD_W)) w_res_word[j % WORD_W] = r_res[j];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_res     <= '0;
            r_cnt     <= '0;
            r_dataout <= '0;
            r_wren    <= 1'b0;
        end else begin
            r_wren <= 1'b0;
            case (r_state)
                S_HDR: begin
                    if (!empty) begin
                        r_op  <= datain[2:0];
                        r_cnt <= '0;
                        r_res <= '0;
                    end
                end
                S_COL_A: begin
                    if (!empty) begin
                        for (int j = 0; j < OP_W; j++) begin
                            if (r_cnt == CNT_W'(j / WORD_W)) r_a[j] <= datain[j % WORD_W];
                        end
                        r_cnt <= w_last_nw ? '0 : r_cnt + CNT_W'(1);
                    end
                end
                S_COL_B: begin
                    if (!empty) begin
                        for (int j = 0; j < OP_W; j++) begin
                            if (r_cnt == CNT_W'(j / WORD_W)) r_b[j] <= datain[j % WORD_W];
                        end
                        r_cnt <= w_last_nw ? '0 : r_cnt + CNT_W'(1);
                    end
                end
                S_EXEC: begin
                    if (r_op == OP_MUL) begin
                        r_res <= {w_mul_sum, r_res[OP_W-1:1]};
                        r_b   <= {1'b0, r_b[OP_W-1:1]};
                        r_cnt <= w_last_mul ? '0 : r_cnt + CNT_W'(1);
                    end else begin
                        r_res <= w_alu;
                    end
                end
                S_EMIT_HDR: begin
                    if (!full) begin
                        r_dataout <= w_status;
                        r_wren    <= 1'b1;
                        r_cnt     <= '0;
                    end
                end
                S_EMIT: begin
                    if (!full) begin
                        r_dataout <= w_res_word;
                        r_wren    <= 1'b1;
                        r_cnt     <= w_last_nr ? '0 : r_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
